// File: rtl/rom_arb_pkg.sv
// Shared constants and grant-owner encoding for the program-ROM arbiter.
package rom_arb_pkg;

    localparam int ROM_ADDR_W = 16;
    localparam int ROM_DATA_W = 16;
    localparam int ROM_DEPTH  = 32768;

    typedef enum logic [1:0] {
        REQ_NONE = 2'b00,
        REQ_I    = 2'b01,
        REQ_D    = 2'b10
    } req_id_t;

endpackage

// File: rtl/rom_arb_burst_ctr.sv
// Saturating count of consecutive data grants taken while fetch waits.
module rom_arb_burst_ctr #(
    parameter int MAX = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_d_gnt,
    input  logic       i_i_req,
    output logic [3:0] o_cnt,
    output logic       o_at_max
);

    localparam logic [3:0] MAX_C = 4'(MAX);

    logic [3:0] r_cnt;

    // Any cycle where fetch is idle or wins clears the run.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= 4'd0;
        end else if (i_d_gnt && i_i_req) begin
            r_cnt <= (r_cnt == MAX_C) ? MAX_C : r_cnt + 4'd1;
        end else begin
            r_cnt <= 4'd0;
        end
    end

    assign o_cnt    = r_cnt;
    assign o_at_max = (r_cnt == MAX_C);

endmodule

// File: rtl/rom_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous program ROM.
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ADDR_W      = ROM_ADDR_W,
    parameter int DATA_W      = ROM_DATA_W,
    parameter int ROM_DEPTH   = rom_arb_pkg::ROM_DEPTH,
    parameter int D_BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [3:0]        busy_cnt
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(ROM_DEPTH);

    logic    w_at_max;
    logic    w_gnt_i;
    logic    w_gnt_d;
    logic    w_oor;
    req_id_t w_owner;
    req_id_t r_owner;
    logic    r_err;

    rom_arb_burst_ctr #(
        .MAX (D_BURST_MAX)
    ) u_burst (
        .clk      (clk),
        .reset    (reset),
        .i_d_gnt  (w_gnt_d),
        .i_i_req  (i_req),
        .o_cnt    (busy_cnt),
        .o_at_max (w_at_max)
    );

    always_comb begin
        w_gnt_d  = 1'b0;
        w_gnt_i  = 1'b0;
        w_owner  = REQ_NONE;
        rom_addr = '0;
        if (!reset) begin
            w_gnt_d = d_req && !(i_req && w_at_max);
            w_gnt_i = i_req && !w_gnt_d;
        end
        unique case (1'b1)
            w_gnt_d: begin
                w_owner  = REQ_D;
                rom_addr = d_addr;
            end
            w_gnt_i: begin
                w_owner  = REQ_I;
                rom_addr = i_addr;
            end
            default: ;
        endcase
        w_oor = (w_owner != REQ_NONE) && ({1'b0, rom_addr} >= DEPTH_C);
    end

    assign i_gnt = w_gnt_i;
    assign d_gnt = w_gnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner <= REQ_NONE;
            r_err   <= 1'b0;
        end else begin
            r_owner <= w_owner;
            r_err   <= w_oor;
        end
    end

    // Gating by reset drops a response whose cycle coincides with reset.
    assign i_rvalid = (r_owner == REQ_I) && !reset;
    assign d_rvalid = (r_owner == REQ_D) && !reset;
    assign rsp_err  = r_err && !reset;
    assign rsp_data = r_err ? '0 : rom_data;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed vector bench for rom_arbiter with a behavioural ROM beside it.
module tb_rom_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req;
    logic [15:0] i_addr, d_addr;
    logic        i_gnt, d_gnt, i_rvalid, d_rvalid, rsp_err;
    logic [15:0] rsp_data, rom_addr, rom_data;
    logic [3:0]  busy_cnt;

    logic [15:0] mem [0:32767];

    int n_vec  = 0;
    int n_cmp  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    rom_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .d_req    (d_req),
        .d_addr   (d_addr),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .rsp_data (rsp_data),
        .rsp_err  (rsp_err),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .busy_cnt (busy_cnt)
    );

    always @(posedge clk) rom_data <= mem[rom_addr[14:0]];

    typedef struct {
        logic        rst;
        logic        ir;
        logic [15:0] ia;
        logic        dr;
        logic [15:0] da;
        logic        ig;
        logic        dg;
        logic [15:0] ra;
        logic        irv;
        logic        drv;
        logic [15:0] rd;
        logic        re;
        logic [3:0]  bc;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(
        logic rst, logic ir, logic [15:0] ia, logic dr, logic [15:0] da,
        logic ig, logic dg, logic [15:0] ra, logic irv, logic drv,
        logic [15:0] rd, logic re, logic [3:0] bc);
        vec_t v;
        v.rst = rst; v.ir = ir; v.ia = ia; v.dr = dr; v.da = da;
        v.ig = ig; v.dg = dg; v.ra = ra; v.irv = irv; v.drv = drv;
        v.rd = rd; v.re = re; v.bc = bc;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got %0h want %0h", nm, got, exp);
        end
    endtask

    task automatic apply(vec_t v, string tag);
        @(negedge clk);
        reset  = v.rst;
        i_req  = v.ir;
        i_addr = v.ia;
        d_req  = v.dr;
        d_addr = v.da;
        #1;
        n_vec++;
        chk({tag, " i_gnt"}, 32'(i_gnt), 32'(v.ig));
        chk({tag, " d_gnt"}, 32'(d_gnt), 32'(v.dg));
        chk({tag, " rom_addr"}, 32'(rom_addr), 32'(v.ra));
        chk({tag, " i_rvalid"}, 32'(i_rvalid), 32'(v.irv));
        chk({tag, " d_rvalid"}, 32'(d_rvalid), 32'(v.drv));
        chk({tag, " rsp_err"}, 32'(rsp_err), 32'(v.re));
        chk({tag, " busy_cnt"}, 32'(busy_cnt), 32'(v.bc));
        if (v.irv || v.drv)
            chk({tag, " rsp_data"}, 32'(rsp_data), 32'(v.rd));
    endtask

    initial begin
        for (int a = 0; a < 32768; a++) mem[a] = 16'(a) ^ 16'h5A00;
        mem[16'h0010] = 16'hBEEF;

        reset = 1'b1; i_req = 1'b0; d_req = 1'b0;
        i_addr = '0; d_addr = '0;
        repeat (2) @(posedge clk);

        // reset: requests present but nothing granted
        tv.push_back(mk(1,1,16'h0010,1,16'h0002, 0,0,16'h0000,0,0,16'h0000,0,0));
        // idle
        for (int k = 0; k < 10; k++)
            tv.push_back(mk(0,0,0,0,0, 0,0,0,0,0,0,0,0));
        // single fetch
        tv.push_back(mk(0,1,16'h0010,0,0, 1,0,16'h0010,0,0,0,0,0));
        tv.push_back(mk(0,0,0,0,0, 0,0,0,1,0,16'hBEEF,0,0));
        // back-to-back data loads
        tv.push_back(mk(0,0,0,1,16'h0001, 0,1,16'h0001,0,0,0,0,0));
        tv.push_back(mk(0,0,0,1,16'h0002, 0,1,16'h0002,0,1,16'h5A01,0,0));
        tv.push_back(mk(0,0,0,1,16'h0003, 0,1,16'h0003,0,1,16'h5A02,0,0));
        tv.push_back(mk(0,0,0,0,0, 0,0,0,0,1,16'h5A03,0,0));
        // out of range
        tv.push_back(mk(0,0,0,1,16'h8000, 0,1,16'h8000,0,0,0,0,0));
        tv.push_back(mk(0,0,0,0,0, 0,0,0,0,1,16'h0000,1,0));
        // last in-range word
        tv.push_back(mk(0,0,0,1,16'h7FFF, 0,1,16'h7FFF,0,0,0,0,0));
        tv.push_back(mk(0,1,16'h0004,0,0, 1,0,16'h0004,0,1,16'h25FF,0,0));
        tv.push_back(mk(0,0,0,1,16'h0005, 0,1,16'h0005,1,0,16'h5A04,0,0));
        tv.push_back(mk(0,0,0,0,0, 0,0,0,0,1,16'h5A05,0,0));
        // contention: D D D D I D D D D I
        tv.push_back(mk(0,1,16'h0020,1,16'h0030, 0,1,16'h0030,0,0,0,0,0));
        tv.push_back(mk(0,1,16'h0020,1,16'h0030, 0,1,16'h0030,0,1,16'h5A30,0,1));
        tv.push_back(mk(0,1,16'h0020,1,16'h0030, 0,1,16'h0030,0,1,16'h5A30,0,2));
        tv.push_back(mk(0,1,16'h0020,1,16'h0030, 0,1,16'h0030,0,1,16'h5A30,0,3));
        tv.push_back(mk(0,1,16'h0020,1,16'h0030, 1,0,16'h0020,0,1,16'h5A30,0,4));
        tv.push_back(mk(0,1,16'h0020,1,16'h0030, 0,1,16'h0030,1,0,16'h5A20,0,0));
        tv.push_back(mk(0,1,16'h0020,1,16'h0030, 0,1,16'h0030,0,1,16'h5A30,0,1));
        tv.push_back(mk(0,1,16'h0020,1,16'h0030, 0,1,16'h0030,0,1,16'h5A30,0,2));
        tv.push_back(mk(0,1,16'h0020,1,16'h0030, 0,1,16'h0030,0,1,16'h5A30,0,3));
        tv.push_back(mk(0,1,16'h0020,1,16'h0030, 1,0,16'h0020,0,1,16'h5A30,0,4));
        tv.push_back(mk(0,0,0,0,0, 0,0,0,1,0,16'h5A20,0,0));

        foreach (tv[i]) apply(tv[i], $sformatf("v%0d", i));

        // reset landing on the response cycle of a fetch
        for (int k = 0; k < 4; k++)
            apply(mk(0,1,16'h0020,1,16'h0030, 0,1,16'h0030,0,k > 0,16'h5A30,0,4'(k)),
                  $sformatf("rb%0d", k));
        apply(mk(0,1,16'h0020,1,16'h0030, 1,0,16'h0020,0,1,16'h5A30,0,4), "rN");
        apply(mk(1,1,16'h0020,1,16'h0030, 0,0,16'h0000,0,0,0,0,0), "rN1");
        apply(mk(1,1,16'h0020,1,16'h0030, 0,0,16'h0000,0,0,0,0,0), "rN2");
        apply(mk(0,1,16'h0020,1,16'h0030, 0,1,16'h0030,0,0,0,0,0), "rN3");
        apply(mk(0,0,0,0,0, 0,0,0,0,1,16'h5A30,0,1), "rN4");

        // request withdrawn before grant: no response follows
        apply(mk(0,1,16'h0020,1,16'h0030, 0,1,16'h0030,0,0,0,0,0), "dw0");
        apply(mk(0,0,0,0,0, 0,0,0,0,1,16'h5A30,0,1), "dw1");
        apply(mk(0,0,0,0,0, 0,0,0,0,0,0,0,0), "dw2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
